// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - SDRAM controller state codes and read-buffer FSM state type
package sdram_pkg;

    localparam logic [4:0] W_IDLE   = 5'd0;
    localparam logic [4:0] W_ACTIVE = 5'd1;
    localparam logic [4:0] W_TRCD   = 5'd2;
    localparam logic [4:0] W_READ   = 5'd3;
    localparam logic [4:0] W_CL     = 5'd4;
    localparam logic [4:0] W_RD     = 5'd5;
    localparam logic [4:0] W_RDDAT  = 5'd6;
    localparam logic [4:0] W_WRITE  = 5'd7;
    localparam logic [4:0] W_WD     = 5'd8;
    localparam logic [4:0] W_TWR    = 5'd9;
    localparam logic [4:0] W_PRECHG = 5'd10;
    localparam logic [4:0] W_TRPACT = 5'd11;

    typedef enum logic [1:0] {
        RB_IDLE,
        RB_REQ,
        RB_FILL
    } rdbuf_st_e;

endpackage

// File: rtl/rdbuf_ram.sv
// rtl/rdbuf_ram.sv - simple dual-port buffer RAM with registered read port
module rdbuf_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Same-address read during write returns the old word, which is what a full buffer needs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sdram_rdbuf.sv
// rtl/sdram_rdbuf.sv - SDRAM-to-VGA read buffer with burst requester; SDRAM_RDBUF_ERRCNT_EN enables err_cnt_o
module sdram_rdbuf
    import sdram_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 10,
    parameter int BURST_LEN  = 256,
    parameter int ST_W       = 5,
    parameter int RDDAT_CODE = int'(W_RDDAT)
) (
    input  logic                  clk_133M_i,
    input  logic                  rst_133i,
    input  logic [ST_W-1:0]       work_st,
    input  logic [DATA_W-1:0]     sdram_data,
    input  logic                  fifo_clear,
    input  logic                  vga_rdfifo,
    input  logic                  burst_ack,
    output logic [DATA_W-1:0]     data_vga,
    output logic                  data_valid,
    output logic [DEPTH_LOG2:0]   fifo_used_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  burst_req,
    output logic                  ovf_o,
    output logic                  udf_o,
    output logic [15:0]           err_cnt_o
);

    localparam logic [DEPTH_LOG2:0]   DEPTH_V  = (DEPTH_LOG2+1)'(2**DEPTH_LOG2);
    localparam logic [DEPTH_LOG2:0]   BURST_V  = (DEPTH_LOG2+1)'(BURST_LEN);
    localparam logic [DEPTH_LOG2:0]   BURST_M1 = (DEPTH_LOG2+1)'(BURST_LEN-1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   used, bcnt, bcnt_nxt;
    logic                  wr_try, rd_ok, wr_ok, wr_drop, rd_rej;
    rdbuf_st_e             st, st_nxt;

    assign wr_try      = (work_st == ST_W'(RDDAT_CODE));
    assign empty_o     = (used == '0);
    assign full_o      = (used == DEPTH_V);
    assign fifo_used_o = used;

    // A flush wins over anything else happening in the same cycle.
    assign rd_ok   = vga_rdfifo & ~empty_o & ~fifo_clear;
    assign wr_ok   = wr_try & (~full_o | rd_ok) & ~fifo_clear;
    assign wr_drop = wr_try & full_o & ~rd_ok & ~fifo_clear;
    assign rd_rej  = vga_rdfifo & empty_o & ~fifo_clear;

    always_ff @(posedge clk_133M_i or posedge rst_133i) begin
        if (rst_133i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            used       <= '0;
            data_valid <= 1'b0;
            ovf_o      <= 1'b0;
            udf_o      <= 1'b0;
        end else if (fifo_clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            used       <= '0;
            data_valid <= 1'b0;
            ovf_o      <= 1'b0;
            udf_o      <= 1'b0;
        end else begin
            data_valid <= rd_ok;
            if (wr_ok)   wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_ok)   rd_ptr <= rd_ptr + PTR_ONE;
            if (wr_drop) ovf_o  <= 1'b1;
            if (rd_rej)  udf_o  <= 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   used <= used + CNT_ONE;
                2'b01:   used <= used - CNT_ONE;
                default: used <= used;
            endcase
        end
    end

    rdbuf_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk_133M_i),
        .rst     (rst_133i),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr),
        .wr_data (sdram_data),
        .rd_en   (rd_ok),
        .rd_addr (rd_ptr),
        .rd_data (data_vga)
    );

    always_ff @(posedge clk_133M_i or posedge rst_133i) begin
        if (rst_133i) begin
            st   <= RB_IDLE;
            bcnt <= '0;
        end else begin
            st   <= st_nxt;
            bcnt <= bcnt_nxt;
        end
    end

    // A burst is only requested once a whole burst is guaranteed to fit.
    always_comb begin
        st_nxt   = st;
        bcnt_nxt = bcnt;
        if (fifo_clear) begin
            st_nxt   = RB_IDLE;
            bcnt_nxt = '0;
        end else begin
            case (st)
                RB_IDLE: begin
                    if ((DEPTH_V - used) >= BURST_V) st_nxt = RB_REQ;
                end
                RB_REQ: begin
                    if (burst_ack) begin
                        st_nxt   = RB_FILL;
                        bcnt_nxt = '0;
                    end
                end
                RB_FILL: begin
                    if (wr_ok) begin
                        if (bcnt == BURST_M1) begin
                            st_nxt   = RB_IDLE;
                            bcnt_nxt = '0;
                        end else begin
                            bcnt_nxt = bcnt + CNT_ONE;
                        end
                    end
                end
                default: begin
                    st_nxt   = RB_IDLE;
                    bcnt_nxt = '0;
                end
            endcase
        end
    end

    assign burst_req = (st == RB_REQ);

`ifdef SDRAM_RDBUF_ERRCNT_EN
    logic [15:0] err_cnt;
    logic [16:0] err_sum;

    assign err_sum = {1'b0, err_cnt} + {16'd0, wr_drop} + {16'd0, rd_rej};

    always_ff @(posedge clk_133M_i or posedge rst_133i) begin
        if (rst_133i) begin
            err_cnt <= '0;
        end else if (fifo_clear) begin
            err_cnt <= '0;
        end else begin
            err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

    assign err_cnt_o = err_cnt;
`else
    assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_sdram_rdbuf.sv
// tb/tb_sdram_rdbuf.sv - directed scoreboard bench for sdram_rdbuf (default and 16-deep instances)
module tb_sdram_rdbuf;
    import sdram_pkg::*;

`ifdef SDRAM_RDBUF_ERRCNT_EN
    localparam bit ERRCNT = 1'b1;
`else
    localparam bit ERRCNT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;

    logic [4:0]  a_st, b_st;
    logic [15:0] a_dat, b_dat;
    logic        a_clr, a_rd, a_ack, b_clr, b_rd, b_ack;
    logic [15:0] a_q, b_q, a_err, b_err;
    logic        a_v, a_empty, a_full, a_breq, a_ovf, a_udf;
    logic        b_v, b_empty, b_full, b_breq, b_ovf, b_udf;
    logic [10:0] a_used;
    logic [4:0]  b_used;

    logic [15:0] a_m[$];
    logic [15:0] b_m[$];
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sdram_rdbuf u_a (
        .clk_133M_i (clk), .rst_133i (rst), .work_st (a_st), .sdram_data (a_dat),
        .fifo_clear (a_clr), .vga_rdfifo (a_rd), .burst_ack (a_ack),
        .data_vga (a_q), .data_valid (a_v), .fifo_used_o (a_used),
        .empty_o (a_empty), .full_o (a_full), .burst_req (a_breq),
        .ovf_o (a_ovf), .udf_o (a_udf), .err_cnt_o (a_err)
    );

    sdram_rdbuf #(.DEPTH_LOG2(4), .BURST_LEN(8)) u_b (
        .clk_133M_i (clk), .rst_133i (rst), .work_st (b_st), .sdram_data (b_dat),
        .fifo_clear (b_clr), .vga_rdfifo (b_rd), .burst_ack (b_ack),
        .data_vga (b_q), .data_valid (b_v), .fifo_used_o (b_used),
        .empty_o (b_empty), .full_o (b_full), .burst_req (b_breq),
        .ovf_o (b_ovf), .udf_o (b_udf), .err_cnt_o (b_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one clock edge; the scoreboards predict and check what the edge produces.
    task automatic tick();
        bit a_r, a_w, b_r, b_w;
        logic [15:0] a_x, b_x;
        a_x = '0;
        b_x = '0;
        a_r = a_rd && (a_m.size() > 0) && !a_clr;
        a_w = (a_st == W_RDDAT) && ((a_m.size() < 1024) || a_r) && !a_clr;
        if (a_r) a_x = a_m.pop_front();
        if (a_w) a_m.push_back(a_dat);
        if (a_clr || rst) a_m.delete();
        b_r = b_rd && (b_m.size() > 0) && !b_clr;
        b_w = (b_st == W_RDDAT) && ((b_m.size() < 16) || b_r) && !b_clr;
        if (b_r) b_x = b_m.pop_front();
        if (b_w) b_m.push_back(b_dat);
        if (b_clr || rst) b_m.delete();
        @(posedge clk);
        #1;
        if (!rst) begin
            chk("a_valid", a_v, a_r);
            if (a_r) chk("a_data", a_q, a_x);
            chk("a_used", a_used, a_m.size());
            chk("b_valid", b_v, b_r);
            if (b_r) chk("b_data", b_q, b_x);
            chk("b_used", b_used, b_m.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        a_st = W_IDLE; a_dat = '0; a_clr = 0; a_rd = 0; a_ack = 0;
        b_st = W_IDLE; b_dat = '0; b_clr = 0; b_rd = 0; b_ack = 0;
        repeat (3) tick();
        chk("rst_data", a_q, 0);
        chk("rst_valid", a_v, 0);
        chk("rst_used", a_used, 0);
        chk("rst_empty", a_empty, 1);
        chk("rst_full", a_full, 0);
        chk("rst_breq", a_breq, 0);
        chk("rst_ovf", a_ovf, 0);
        chk("rst_udf", a_udf, 0);
        chk("rst_err", a_err, 0);
        chk("rst_b_empty", b_empty, 1);
        rst = 1'b0;

        // Burst handshake from empty
        tick();
        chk("breq_first", a_breq, 1);
        repeat (3) tick();
        chk("breq_held", a_breq, 1);
        a_ack = 1;
        tick();
        a_ack = 0;
        chk("breq_after_ack", a_breq, 0);
        for (int i = 0; i < 256; i++) begin
            a_st = W_RDDAT;
            a_dat = 16'h1000 + 16'(i);
            tick();
            if (i == 0 || i == 254 || i == 255) chk("breq_fill", a_breq, 0);
        end
        a_st = W_IDLE;
        tick();
        chk("breq_rearm", a_breq, 1);
        a_rd = 1;
        repeat (256) tick();
        a_rd = 0;
        tick();
        chk("drain_empty", a_empty, 1);

        // Ramp 0..199 then read back
        for (int i = 0; i < 200; i++) begin
            a_st = W_RDDAT;
            a_dat = 16'(i);
            tick();
        end
        a_st = W_IDLE;
        chk("ramp_used", a_used, 200);
        a_rd = 1;
        repeat (200) tick();
        a_rd = 0;
        tick();
        chk("ramp_empty", a_empty, 1);
        chk("ramp_ovf", a_ovf, 0);
        chk("ramp_udf", a_udf, 0);

        // Underflow
        a_rd = 1;
        repeat (3) tick();
        a_rd = 0;
        chk("udf_set", a_udf, 1);
        chk("udf_err", a_err, ERRCNT ? 3 : 0);

        // Flush in the middle of a burst fill
        chk("breq_before_fill", a_breq, 1);
        a_ack = 1;
        tick();
        a_ack = 0;
        for (int i = 0; i < 100; i++) begin
            a_st = W_RDDAT;
            a_dat = 16'h2000 + 16'(i);
            tick();
        end
        chk("fill_breq", a_breq, 0);
        a_clr = 1; a_rd = 1; a_dat = 16'hDEAD;
        tick();
        a_clr = 0; a_rd = 0;
        chk("clr_empty", a_empty, 1);
        chk("clr_ovf", a_ovf, 0);
        chk("clr_udf", a_udf, 0);
        chk("clr_err", a_err, 0);
        chk("clr_breq", a_breq, 0);
        for (int j = 0; j < 3; j++) begin
            a_dat = 16'h3000 + 16'(j);
            tick();
            if (j == 0) chk("clr_rearm", a_breq, 1);
        end
        a_st = W_IDLE;
        a_rd = 1;
        repeat (3) tick();
        a_rd = 0;
        tick();

        // 16-deep instance: overflow
        b_st = W_RDDAT;
        for (int i = 0; i < 20; i++) begin
            b_dat = 16'(i);
            tick();
            if (i == 14) chk("b_not_full", b_full, 0);
            if (i == 15) begin
                chk("b_full", b_full, 1);
                chk("b_ovf_clean", b_ovf, 0);
            end
        end
        chk("b_ovf", b_ovf, 1);
        chk("b_used16", b_used, 16);
        chk("b_err", b_err, ERRCNT ? 4 : 0);

        // Full buffer with simultaneous write and read
        b_st = W_IDLE; b_clr = 1;
        tick();
        b_clr = 0;
        b_st = W_RDDAT;
        for (int i = 0; i < 16; i++) begin
            b_dat = 16'h100 + 16'(i);
            tick();
        end
        b_rd = 1;
        for (int k = 0; k < 5; k++) begin
            b_dat = 16'h200 + 16'(k);
            tick();
            chk("b_rw_full", b_full, 1);
            chk("b_rw_ovf", b_ovf, 0);
        end
        b_st = W_IDLE;
        repeat (16) tick();
        b_rd = 0;
        tick();
        chk("b_final_empty", b_empty, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sdram_rdbuf.md
SDRAM_RDBUF -- requirements
Module: sdram_rdbuf

Interface
REQ-001 Parameter DATA_W, default 16, SDRAM data and pixel word width.
REQ-002 Parameter DEPTH_LOG2, default 10, buffer depth = 2**DEPTH_LOG2 words.
REQ-003 Parameter BURST_LEN, default 256, words per SDRAM read burst; legal range 1..2**DEPTH_LOG2.
REQ-004 Parameter ST_W, default 5, width of work_st.
REQ-005 Parameter RDDAT_CODE, default 6, work_st value meaning read-data phase.
REQ-006 clk_133M_i  input  1  sole clock; all logic on rising edge.
REQ-007 rst_133i  input  1  asynchronous, active-high reset.
REQ-008 work_st  input  ST_W  SDRAM controller state.
REQ-009 sdram_data  input  DATA_W  SDRAM read data, valid while work_st==RDDAT_CODE.
REQ-010 fifo_clear  input  1  synchronous buffer flush.
REQ-011 vga_rdfifo  input  1  pixel read request.
REQ-012 burst_ack  input  1  controller has accepted burst_req.
REQ-013 data_vga  output  DATA_W  pixel word, registered.
REQ-014 data_valid  output  1  data_vga holds a newly read word this cycle.
REQ-015 fifo_used_o  output  DEPTH_LOG2+1  occupancy, 0..2**DEPTH_LOG2.
REQ-016 empty_o, full_o  output  1 each  occupancy==0 / occupancy==depth.
REQ-017 burst_req  output  1  request for one SDRAM read burst.
REQ-018 ovf_o, udf_o  output  1 each  sticky overflow / underflow flags.
REQ-019 err_cnt_o  output  16  dropped-access counter (see Configuration).

Function
REQ-020 Write attempt = work_st==RDDAT_CODE; accepted if !full_o, or if full_o and a read is accepted the same cycle.
REQ-021 Read attempt = vga_rdfifo; accepted only if !empty_o; no fall-through (write into empty buffer readable next cycle earliest).
REQ-022 Accepted read: data_vga updates and data_valid=1 on the next rising edge (latency 1); otherwise data_valid=0 and data_vga holds.
REQ-023 fifo_used_o = +1 write only, -1 read only, unchanged for both or neither; pointers wrap modulo depth.
REQ-024 Write attempt while full with no accepted read: data dropped, ovf_o set.
REQ-025 Read attempt while empty: ignored, udf_o set; data_valid stays 0.
REQ-026 Burst FSM states IDLE, REQ, FILL; IDLE->REQ when depth-fifo_used_o >= BURST_LEN; burst_req=1 only in REQ.
REQ-027 REQ->FILL on burst_ack; burst_req held until then; burst_ack outside REQ ignored.
REQ-028 FILL counts accepted writes; FILL->IDLE on the BURST_LEN-th; next REQ no earlier than one cycle after.
REQ-029 fifo_clear: next edge empties buffer, fifo_used_o=0, FSM=IDLE, burst counter=0, ovf_o=udf_o=0, data_valid=0; overrides same-cycle reads/writes.
REQ-030 fifo_clear in REQ or FILL aborts the burst; remaining RDDAT words after clear are written normally.

Reset
REQ-031 While rst_133i=1: data_vga=0, data_valid=0, fifo_used_o=0, empty_o=1, full_o=0, burst_req=0, ovf_o=0, udf_o=0, err_cnt_o=0, FSM=IDLE.
REQ-032 Reset mid-burst discards all contents; RAM contents need not be cleared.

Configuration
REQ-033 Macro SDRAM_RDBUF_ERRCNT_EN defined: err_cnt_o counts each dropped write and rejected read, saturates at 16'hFFFF, cleared by reset or fifo_clear; both events same cycle add 2.
REQ-034 Macro undefined: err_cnt_o tied to 0, no counter logic.

Structure
REQ-035 Shared package sdram_pkg holds W_IDLE..W_TRPACT state codes (W_RDDAT=6) and the rdbuf FSM state enum.
REQ-036 One sub-module rdbuf_ram: simple dual-port RAM, DATA_W x 2**DEPTH_LOG2, registered read port.

Verification
REQ-037 Reset, 200 cycles RDDAT with ramp 0..199, then 200 reads -> data_vga 0..199 in order, each 1 cycle after read, fifo_used_o back to 0.
REQ-038 DEPTH_LOG2=4: 20 writes, no reads -> full_o after 16, fifo_used_o=16, ovf_o=1, err_cnt_o=4 with macro, 0 without.
REQ-039 Full buffer, simultaneous write+read for 5 cycles -> fifo_used_o stays 16, ovf_o=0, output order preserved.
REQ-040 Empty buffer, vga_rdfifo=1 for 3 cycles -> data_valid=0, udf_o=1, err_cnt_o=3 with macro.
REQ-041 Defaults, empty: burst_req=1; ack at cycle 5 -> burst_req=0 next edge; 256 writes -> IDLE, burst_req reasserts since 768 free.
REQ-042 fifo_clear mid-FILL with 100 words held -> next cycle fifo_used_o=0, flags 0, FSM IDLE, burst_req=1 following cycle.
